// File: rtl/vram_console_ctrl.sv
// Byte-stream text console writer for the 80x30 character VRAM: cursor tracking,
// control-code decode, hardware scroll (row copy + blank fill) and clear-screen.
//   state     | meaning
//   IDLE      | ready for a byte; decodes it on accept
//   WRITE     | single cell write, cursor update at end of cycle
//   SCROLL_RD | read cell p+COLS
//   SCROLL_WR | write the read word to cell p
//   FILL      | blank fill, one cell per cycle
module vram_console_ctrl #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 30,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic [7:0]  char_in,
  input  logic [7:0]  attr_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [19:0] vram_addr,
  output logic [15:0] vram_wdata,
  output logic        vram_we,
  output logic        vram_re,
  input  logic [15:0] vram_rdata,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        busy
);

  localparam logic [19:0] ROW_LEN     = 20'(COLS);
  localparam logic [19:0] LAST_CELL   = 20'(ROWS*COLS-1);
  localparam logic [19:0] SCROLL_LAST = 20'((ROWS-1)*COLS-1);
  localparam logic [19:0] BOTTOM_ROW  = 20'((ROWS-1)*COLS);
  localparam logic [6:0]  X_MAX       = 7'(COLS-1);
  localparam logic [4:0]  Y_MAX       = 5'(ROWS-1);

  typedef enum logic [2:0] {IDLE, WRITE, SCROLL_RD, SCROLL_WR, FILL} state_t;

  state_t      state_q;
  logic [6:0]  cx_q, nx_q;
  logic [4:0]  cy_q, ny_q;
  logic [19:0] addr_q, ptr_q;
  logic [15:0] wdata_q;
  logic [7:0]  attr_q;
  logic        we_q, re_q, scroll_q, clr_q;

  logic [6:0]  bs_x_d, adv_x_d;
  logic [4:0]  bs_y_d, adv_y_d;
  logic        bs_move_d, adv_scroll_d;
  logic [19:0] cur_cell_d, bs_cell_d;

  always_comb begin
    bs_x_d       = cx_q;
    bs_y_d       = cy_q;
    bs_move_d    = 1'b1;
    if (cx_q != 7'd0) begin
      bs_x_d = cx_q - 7'd1;
    end else if (cy_q != 5'd0) begin
      bs_x_d = X_MAX;
      bs_y_d = cy_q - 5'd1;
    end else begin
      bs_move_d = 1'b0;
    end
    adv_x_d      = cx_q + 7'd1;
    adv_y_d      = cy_q;
    adv_scroll_d = 1'b0;
    if (cx_q == X_MAX) begin
      adv_x_d = 7'd0;
      if (cy_q != Y_MAX) adv_y_d = cy_q + 5'd1;
      else               adv_scroll_d = 1'b1;
    end
  end

  assign cur_cell_d = 20'(cy_q) * ROW_LEN + 20'(cx_q);
  assign bs_cell_d  = 20'(bs_y_d) * ROW_LEN + 20'(bs_x_d);

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cx_q     <= '0;
      cy_q     <= '0;
      nx_q     <= '0;
      ny_q     <= '0;
      addr_q   <= '0;
      ptr_q    <= '0;
      wdata_q  <= '0;
      attr_q   <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      scroll_q <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          we_q <= 1'b0;
          re_q <= 1'b0;
          if (char_valid) begin
            attr_q <= attr_in;
            case (char_in)
              8'h0A: begin
                cx_q <= '0;
                if (cy_q != Y_MAX) begin
                  cy_q <= cy_q + 5'd1;
                end else begin
                  state_q <= SCROLL_RD;
                  ptr_q   <= '0;
                  addr_q  <= ROW_LEN;
                  re_q    <= 1'b1;
                end
              end
              8'h0D: cx_q <= '0;
              8'h08: begin
                if (bs_move_d) begin
                  state_q  <= WRITE;
                  addr_q   <= bs_cell_d;
                  wdata_q  <= {attr_in, BLANK_CHAR};
                  we_q     <= 1'b1;
                  nx_q     <= bs_x_d;
                  ny_q     <= bs_y_d;
                  scroll_q <= 1'b0;
                end
              end
              8'h0C: begin
                state_q <= FILL;
                addr_q  <= '0;
                wdata_q <= {attr_in, BLANK_CHAR};
                we_q    <= 1'b1;
                clr_q   <= 1'b1;
              end
              default: begin
                state_q  <= WRITE;
                addr_q   <= cur_cell_d;
                wdata_q  <= {attr_in, char_in};
                we_q     <= 1'b1;
                nx_q     <= adv_x_d;
                ny_q     <= adv_y_d;
                scroll_q <= adv_scroll_d;
              end
            endcase
          end
        end
        WRITE: begin
          cx_q <= nx_q;
          cy_q <= ny_q;
          we_q <= 1'b0;
          if (scroll_q) begin
            state_q <= SCROLL_RD;
            ptr_q   <= '0;
            addr_q  <= ROW_LEN;
            re_q    <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        SCROLL_RD: begin
          re_q    <= 1'b0;
          we_q    <= 1'b1;
          addr_q  <= ptr_q;
          state_q <= SCROLL_WR;
        end
        SCROLL_WR: begin
          we_q <= 1'b0;
          if (ptr_q == SCROLL_LAST) begin
            state_q <= FILL;
            addr_q  <= BOTTOM_ROW;
            wdata_q <= {attr_q, BLANK_CHAR};
            we_q    <= 1'b1;
            clr_q   <= 1'b0;
          end else begin
            ptr_q   <= ptr_q + 20'd1;
            addr_q  <= ptr_q + 20'd1 + ROW_LEN;
            re_q    <= 1'b1;
            state_q <= SCROLL_RD;
          end
        end
        FILL: begin
          if (addr_q == LAST_CELL) begin
            we_q    <= 1'b0;
            state_q <= IDLE;
            clr_q   <= 1'b0;
            if (clr_q) begin
              cx_q <= '0;
              cy_q <= '0;
            end
          end else begin
            addr_q <= addr_q + 20'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The copied word comes straight from the read issued in the previous cycle.
  assign vram_wdata = (state_q == SCROLL_WR) ? vram_rdata : wdata_q;
  assign vram_addr  = addr_q;
  assign vram_we    = we_q;
  assign vram_re    = re_q;
  assign char_ready = (state_q == IDLE);
  assign busy       = ~char_ready;
  assign cursor_x   = cx_q;
  assign cursor_y   = cy_q;

endmodule

// File: tb/tb_vram_console_ctrl.sv
// Self-checking bench for vram_console_ctrl: reference VRAM/cursor model feeds an
// expected-access queue that is checked cycle by cycle against the DUT port.
module tb_vram_console_ctrl;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS*ROWS;

  logic        clk_25mhz = 1'b0;
  logic        reset;
  logic [7:0]  char_in, attr_in;
  logic        char_valid;
  logic        char_ready;
  logic [19:0] vram_addr;
  logic [15:0] vram_wdata;
  logic        vram_we, vram_re;
  logic [15:0] vram_rdata;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy;

  vram_console_ctrl dut (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .char_in   (char_in),
    .attr_in   (attr_in),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .vram_addr (vram_addr),
    .vram_wdata(vram_wdata),
    .vram_we   (vram_we),
    .vram_re   (vram_re),
    .vram_rdata(vram_rdata),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .busy      (busy)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  function automatic logic [15:0] fill_pat(int a);
    return 16'((a * 40503) ^ 16'hA5C3);
  endfunction

  // VRAM behavioural model: unwritten cells return a per-address pattern.
  bit [15:0] mem   [CELLS];
  bit        wmask [CELLS];
  always @(posedge clk_25mhz) begin
    if (vram_re) begin
      if (vram_addr < 20'(CELLS) && wmask[vram_addr[11:0]]) vram_rdata <= mem[vram_addr[11:0]];
      else vram_rdata <= fill_pat(int'(vram_addr));
    end
    if (vram_we && vram_addr < 20'(CELLS)) begin
      mem[vram_addr[11:0]]   <= vram_wdata;
      wmask[vram_addr[11:0]] <= 1'b1;
    end
  end

  typedef struct packed {
    logic        w;
    logic [19:0] a;
    logic [15:0] d;
  } ev_t;

  ev_t       expq[$];
  bit [15:0] refm [CELLS];
  bit        refw [CELLS];
  int        mx, my;
  int        total, bad;

  function automatic logic [15:0] ref_rd(int a);
    return refw[a] ? refm[a] : fill_pat(a);
  endfunction

  task automatic push_w(int a, logic [15:0] d);
    expq.push_back({1'b1, 20'(a), d});
    refm[a] = d;
    refw[a] = 1'b1;
  endtask

  task automatic model_scroll(logic [7:0] a);
    for (int p = 0; p < (ROWS-1)*COLS; p++) begin
      expq.push_back({1'b0, 20'(p+COLS), 16'h0});
      push_w(p, ref_rd(p+COLS));
    end
    for (int p = (ROWS-1)*COLS; p < CELLS; p++) push_w(p, {a, 8'h20});
  endtask

  task automatic model(logic [7:0] c, logic [7:0] a, output int exp_busy);
    exp_busy = 0;
    case (c)
      8'h0A: begin
        mx = 0;
        if (my < ROWS-1) my++;
        else begin model_scroll(a); exp_busy = 4720; end
      end
      8'h0D: mx = 0;
      8'h08: begin
        if (mx > 0 || my > 0) begin
          if (mx > 0) mx--;
          else begin mx = COLS-1; my--; end
          push_w(my*COLS + mx, {a, 8'h20});
          exp_busy = 1;
        end
      end
      8'h0C: begin
        for (int i = 0; i < CELLS; i++) push_w(i, {a, 8'h20});
        mx = 0; my = 0;
        exp_busy = 2400;
      end
      default: begin
        push_w(my*COLS + mx, {a, c});
        exp_busy = 1;
        if (mx < COLS-1) mx++;
        else begin
          mx = 0;
          if (my < ROWS-1) my++;
          else begin model_scroll(a); exp_busy = 1 + 4720; end
        end
      end
    endcase
  endtask

  task automatic step_check();
    ev_t obs, e;
    @(negedge clk_25mhz);
    total++;
    if ((vram_we && vram_re) || busy !== ~char_ready) begin
      bad++;
      $display("FAIL port_consistency we=%0b re=%0b busy=%0b ready=%0b required we&re=0 busy=~ready",
               vram_we, vram_re, busy, char_ready);
    end
    if (vram_we || vram_re) begin
      obs = {vram_we, vram_addr, vram_we ? vram_wdata : 16'h0};
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_access got we=%0b addr=%0d data=%h required none", obs.w, obs.a, obs.d);
      end else begin
        e = expq.pop_front();
        if (obs !== e) begin
          bad++;
          $display("FAIL vram_access got we=%0b addr=%0d data=%h required we=%0b addr=%0d data=%h",
                   obs.w, obs.a, obs.d, e.w, e.a, e.d);
        end
      end
    end
  endtask

  // Caller is at a negedge with char_ready high; returns at a negedge with ready high.
  task automatic send(logic [7:0] c, logic [7:0] a, bit hold);
    int expb, nb;
    bit done;
    model(c, a, expb);
    char_in = c; attr_in = a; char_valid = 1'b1;
    @(posedge clk_25mhz);
    #1;
    if (hold) char_in = 8'h55;
    else char_valid = 1'b0;
    nb = 0; done = 1'b0;
    for (int i = 0; i < 6000 && !done; i++) begin
      step_check();
      if (char_ready) begin done = 1'b1; char_valid = 1'b0; end
      else nb++;
    end
    char_valid = 1'b0;
    total++;
    if (!done) begin bad++; $display("FAIL ready_timeout byte=%h got busy after %0d cycles required ready", c, nb); end
    total++;
    if (nb != expb) begin bad++; $display("FAIL busy_cycles byte=%h got %0d required %0d", c, nb, expb); end
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL missing_accesses byte=%h got %0d still pending required 0", c, expq.size());
      expq.delete();
    end
    total++;
    if (cursor_x !== 7'(mx) || cursor_y !== 5'(my)) begin
      bad++;
      $display("FAIL cursor byte=%h got (%0d,%0d) required (%0d,%0d)", c, cursor_x, cursor_y, mx, my);
    end
  endtask

  task automatic check_reset_state(string tag);
    total++;
    if (vram_we !== 1'b0 || vram_re !== 1'b0 || char_ready !== 1'b1 || busy !== 1'b0 ||
        vram_addr !== 20'd0 || vram_wdata !== 16'd0 || cursor_x !== 7'd0 || cursor_y !== 5'd0) begin
      bad++;
      $display("FAIL %s got we=%0b re=%0b ready=%0b addr=%0d wdata=%h cur=(%0d,%0d) required 0,0,1,0,0,(0,0)",
               tag, vram_we, vram_re, char_ready, vram_addr, vram_wdata, cursor_x, cursor_y);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; char_valid = 1'b0; char_in = 8'h00; attr_in = 8'h00;
    repeat (3) @(negedge clk_25mhz);
    check_reset_state("reset_held");
    reset = 1'b0;
    mx = 0; my = 0;
    for (int i = 0; i < 10; i++) begin
      step_check();
      check_reset_state("idle_after_reset");
    end
  endtask

  task automatic test_char_a();
    send(8'h41, 8'h0F, 1'b0);
  endtask

  task automatic test_backspace();
    send(8'h08, 8'h0F, 1'b0);
    send(8'h08, 8'h0F, 1'b0);
    for (int i = 0; i < 3; i++) send(8'h0A, 8'h00, 1'b0);
    send(8'h08, 8'h3C, 1'b1);
  endtask

  task automatic test_row_wrap();
    send(8'h0D, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) send(8'h0A, 8'h00, 1'b0);
    for (int i = 0; i < COLS-1; i++) send(8'(8'h61 + i % 26), 8'(i), 1'b0);
    send(8'h5A, 8'h07, 1'b0);
  endtask

  task automatic test_clear();
    send(8'h0C, 8'h1E, 1'b1);
  endtask

  task automatic test_scroll();
    for (int i = 0; i < ROWS-1; i++) begin
      send(8'(8'h30 + i % 10), 8'(8'h40 + i), 1'b0);
      send(8'h0A, 8'h00, 1'b0);
    end
    send(8'h0A, 8'h70, 1'b1);
    for (int i = 0; i < COLS-1; i++) send(8'(8'h21 + i), 8'(8'h80 + i), 1'b0);
    send(8'h51, 8'h2A, 1'b1);
  endtask

  task automatic test_reset_abort();
    char_in = 8'h0A; attr_in = 8'h11; char_valid = 1'b1;
    @(posedge clk_25mhz);
    #1 char_valid = 1'b0;
    repeat (100) @(negedge clk_25mhz);
    total++;
    if (!(vram_we || vram_re) || char_ready !== 1'b0) begin
      bad++;
      $display("FAIL scroll_in_progress got we=%0b re=%0b ready=%0b required access active, ready=0",
               vram_we, vram_re, char_ready);
    end
    #5 reset = 1'b1;
    #1 check_reset_state("async_reset_abort");
    @(negedge clk_25mhz);
    reset = 1'b0;
    mx = 0; my = 0;
    expq.delete();
    step_check();
    check_reset_state("after_abort_release");
  endtask

  task automatic test_back_to_back();
    send(8'h48, 8'h0A, 1'b0);
    send(8'h69, 8'h0B, 1'b0);
    send(8'h0C, 8'h05, 1'b1);
    send(8'h21, 8'h06, 1'b0);
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_char_a();
    test_backspace();
    test_row_wrap();
    test_clear();
    test_scroll();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
